vga_frame_capture: RTL and testbench
====================================

# vga_frame_capture

Receive-side counterpart of the VGA output path: samples an incoming VGA stream (hsync, vsync, 8-bit R/G/B) on a pixel-enable strobe and writes one armed frame into a frame buffer as 8-bit grayscale. It sits between the external VGA/loopback pins and the frame-memory write port. It reports completion and timing errors to the control logic.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_BP, 48, pixel strobes from hsync deassertion (rising edge) to first active pixel
- V_BP, 33, lines (hsync falling edges) from vsync deassertion to first active line
- AW, 19, write-address width (must satisfy 2^AW >= H_ACTIVE*V_ACTIVE)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pix_ce  in  1  one-clk pixel strobe (clk/2 for 25 MHz pixel rate)
- vga_hsync  in  1  active-low horizontal sync
- vga_vsync  in  1  active-low vertical sync
- vga_r, vga_g, vga_b  in  8 each  pixel colour
- arm  in  1  one-clk pulse: capture the next complete frame
- busy  out  1  high from arm acceptance until done/abort
- frame_done  out  1  one-clk pulse after last pixel written
- err  out  2  sticky: [0] short line, [1] short frame; cleared by arm
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  AW  linear address, line*H_ACTIVE + pixel
- wr_data  out  8  grayscale pixel

## Operation
- Input conditioning: hsync/vsync pass through 2-flop synchronizers; R/G/B delayed by 2 flops to stay aligned. Edges detected on the synchronized signals; all edge/strobe logic uses the pix_ce-qualified samples.
- Grayscale: wr_data = (r + 2*g + b) >> 2, computed in 10 bits, upper 8 bits taken; no rounding.
- FSM states: IDLE, WAIT_VS, V_PORCH, WAIT_HS, H_PORCH, ACTIVE, DONE.
  - IDLE: arm -> WAIT_VS, clears err, addr=0, line=0. arm ignored in every other state.
  - WAIT_VS: vsync rising edge -> V_PORCH, vline=0.
  - V_PORCH: each hsync falling edge increments vline; at vline==V_BP -> WAIT_HS.
  - WAIT_HS: hsync rising edge -> H_PORCH, hcnt=0.
  - H_PORCH: each pix_ce increments hcnt; at hcnt==H_BP-1 -> ACTIVE, pix=0.
  - ACTIVE: each pix_ce writes one pixel, pix++, addr++. After pixel H_ACTIVE-1: line++; line==V_ACTIVE -> DONE else WAIT_HS.
  - DONE: one cycle, frame_done=1, -> IDLE.
- Errors: hsync falling edge in ACTIVE before H_ACTIVE pixels -> err[0]=1, -> IDLE. vsync falling edge in WAIT_HS/H_PORCH/ACTIVE before V_ACTIVE lines -> err[1]=1, -> IDLE. Both same cycle: set both bits. No frame_done on abort.
- Address never wraps: last write is H_ACTIVE*V_ACTIVE-1.

## Timing
- Reset values: busy=0, frame_done=0, err=0, wr_en=0, wr_addr=0, wr_data=0, state IDLE, all counters 0.
- Pipeline latency: pin change to synchronized sample = 2 clk; pixel sampled on pix_ce cycle appears on wr_en/wr_addr/wr_data on the next clk (registered), wr_en high exactly one clk.
- busy rises the clk after arm; falls the clk after frame_done (or in the abort cycle +1).
- frame_done asserts the clk after the final wr_en.
- reset deassertion mid-frame: block restarts in IDLE, waits for new arm; no partial writes continue.
- pix_ce low: no counter in H_PORCH/ACTIVE advances; edges still detected every clk.

## Structure
- Package vga_pkg: state enum type, default timing constants (640/480/48/33, plus front porch/sync widths shared with the output timing generator), grayscale width constant.
- Sub-module sync_edge_detect (2-flop synchronizer + rise/fall pulse), instantiated for hsync and vsync.

## Test plan
Use H_ACTIVE=8, V_ACTIVE=4, H_BP=2, V_BP=1 with a behavioural VGA source.
- Arm, one clean frame of ramp data (r=g=b=addr) -> 32 writes, addresses 0..31, wr_data=addr, frame_done one pulse, err=0.
- Pixel r=255,g=0,b=0 -> wr_data=63; r=g=b=255 -> 255; r=1,g=1,b=1 -> 1.
- Line truncated to 5 pixels on line 2 -> err=2'b01, 21 writes total, no frame_done, busy falls.
- vsync asserted after 2 lines -> err=2'b10, 16 writes, back to IDLE; next arm clears err and captures full frame.
- Arm issued mid-frame -> no writes until next vsync rising edge; second arm during busy ignored.
- reset low during ACTIVE -> all outputs 0 next clk, no writes after release until arm.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA capture path: capture FSM state type,
// default 640x480 timing constants (also used by the output timing
// generator) and the grayscale conversion helper.
// ---------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VS,
        S_V_PORCH,
        S_WAIT_HS,
        S_H_PORCH,
        S_ACTIVE,
        S_DONE
    } cap_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int H_BP_DEF     = 48;
    localparam int V_BP_DEF     = 33;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;

    localparam int GRAY_SUM_W   = 10;
    localparam int PIX_W        = 8;

    // Luma approximation (r + 2g + b) / 4, truncated. The 10-bit sum holds
    // the worst case 255 + 510 + 255 = 1020, so the top 8 bits are the result.
    function automatic logic [PIX_W-1:0] gray_from_rgb(input logic [7:0] r,
                                                       input logic [7:0] g,
                                                       input logic [7:0] b);
        logic [GRAY_SUM_W-1:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[GRAY_SUM_W-1 -: PIX_W];
    endfunction

endpackage

// File: rtl/vga_frame_capture_if.sv
// ---------------------------------------------------------------------------
// vga_frame_capture_if
// Frame-buffer write port between the capture block (master) and the frame
// memory (slave).
//   wr_en   : one-clk write strobe
//   wr_addr : linear pixel address, line*H_ACTIVE + pixel
//   wr_data : 8-bit grayscale pixel
// ---------------------------------------------------------------------------
interface vga_frame_capture_if
    import vga_pkg::*;
#(
    parameter int AW = 19
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [PIX_W-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Two-flop synchronizer for an asynchronous level followed by a one-clk
// rise/fall pulse generator running every clk.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_async        : asynchronous input level
//   o_rise, o_fall : one-clk pulses on the synchronized level
// ---------------------------------------------------------------------------
module sync_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to the idle level of the (active-low) sync so that releasing
    // reset never fabricates an edge on its own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/vga_frame_capture.sv
// ---------------------------------------------------------------------------
// vga_frame_capture
// Captures one armed VGA frame as 8-bit grayscale into a frame buffer.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_pix_ce                : one-clk pixel strobe
//   i_vga_hsync/i_vga_vsync : active-low syncs (asynchronous)
//   i_vga_r/g/b             : pixel colour
//   i_arm                   : one-clk pulse, capture the next full frame
//   o_busy                  : armed and not yet finished/aborted
//   o_frame_done            : one-clk pulse after the final write
//   o_err                   : sticky [0] short line, [1] short frame
//   o_fb                    : frame-buffer write port (master)
// ---------------------------------------------------------------------------
module vga_frame_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int AW       = 19
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pix_ce,
    input  logic       i_vga_hsync,
    input  logic       i_vga_vsync,
    input  logic [7:0] i_vga_r,
    input  logic [7:0] i_vga_g,
    input  logic [7:0] i_vga_b,
    input  logic       i_arm,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic [1:0] o_err,
    vga_frame_capture_if.master o_fb
);

    localparam int CW = 16;
    localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HBP_LAST = CW'(H_BP - 1);
    localparam logic [CW-1:0] VBP_LAST = CW'(V_BP - 1);

    cap_state_e       r_state,       w_state_nxt;
    logic [CW-1:0]    r_vline,       w_vline_nxt;
    logic [CW-1:0]    r_hcnt,        w_hcnt_nxt;
    logic [CW-1:0]    r_pix,         w_pix_nxt;
    logic [CW-1:0]    r_line,        w_line_nxt;
    logic [AW-1:0]    r_addr,        w_addr_nxt;
    logic [1:0]       r_err,         w_err_nxt;
    logic             r_wr_en,       w_wr_en_nxt;
    logic [AW-1:0]    r_wr_addr,     w_wr_addr_nxt;
    logic [PIX_W-1:0] r_wr_data,     w_wr_data_nxt;
    logic             r_frame_done,  w_frame_done_nxt;

    logic [23:0]      r_rgb_d1;
    logic [23:0]      r_rgb_d2;
    logic [PIX_W-1:0] w_gray;
    logic             w_hs_rise, w_hs_fall;
    logic             w_vs_rise, w_vs_fall;

    sync_edge_detect #(.RESET_VAL(1'b1)) u_hs_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_vga_hsync),
        .o_rise  (w_hs_rise),
        .o_fall  (w_hs_fall)
    );

    sync_edge_detect #(.RESET_VAL(1'b1)) u_vs_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_vga_vsync),
        .o_rise  (w_vs_rise),
        .o_fall  (w_vs_fall)
    );

    // Colour goes through the same two-stage delay as the syncs, so the
    // pixel seen on a strobe belongs to the same slot as the sync edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rgb_d1 <= '0;
            r_rgb_d2 <= '0;
        end else begin
            r_rgb_d1 <= {i_vga_r, i_vga_g, i_vga_b};
            r_rgb_d2 <= r_rgb_d1;
        end
    end

    assign w_gray = gray_from_rgb(r_rgb_d2[23:16], r_rgb_d2[15:8], r_rgb_d2[7:0]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_vline      <= '0;
            r_hcnt       <= '0;
            r_pix        <= '0;
            r_line       <= '0;
            r_addr       <= '0;
            r_err        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_vline      <= w_vline_nxt;
            r_hcnt       <= w_hcnt_nxt;
            r_pix        <= w_pix_nxt;
            r_line       <= w_line_nxt;
            r_addr       <= w_addr_nxt;
            r_err        <= w_err_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // Sync-edge aborts take priority over a pixel strobe arriving in the
    // same cycle, so a short line never writes a pixel past its hsync.
    always_comb begin
        w_state_nxt      = r_state;
        w_vline_nxt      = r_vline;
        w_hcnt_nxt       = r_hcnt;
        w_pix_nxt        = r_pix;
        w_line_nxt       = r_line;
        w_addr_nxt       = r_addr;
        w_err_nxt        = r_err;
        w_wr_en_nxt      = 1'b0;
        w_wr_addr_nxt    = r_wr_addr;
        w_wr_data_nxt    = r_wr_data;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_arm) begin
                    w_state_nxt = S_WAIT_VS;
                    w_err_nxt   = '0;
                    w_addr_nxt  = '0;
                    w_line_nxt  = '0;
                    w_hcnt_nxt  = '0;
                    w_pix_nxt   = '0;
                end
            end
            S_WAIT_VS: begin
                if (w_vs_rise) begin
                    w_state_nxt = S_V_PORCH;
                    w_vline_nxt = '0;
                end
            end
            S_V_PORCH: begin
                if (w_hs_fall) begin
                    w_vline_nxt = r_vline + 1'b1;
                    if (r_vline == VBP_LAST) begin
                        w_state_nxt = S_WAIT_HS;
                    end
                end
            end
            S_WAIT_HS: begin
                if (w_vs_fall) begin
                    w_err_nxt   = r_err | 2'b10;
                    w_state_nxt = S_IDLE;
                end else if (w_hs_rise) begin
                    w_state_nxt = S_H_PORCH;
                    w_hcnt_nxt  = '0;
                end
            end
            S_H_PORCH: begin
                if (w_vs_fall) begin
                    w_err_nxt   = r_err | 2'b10;
                    w_state_nxt = S_IDLE;
                end else if (i_pix_ce) begin
                    if (r_hcnt == HBP_LAST) begin
                        w_state_nxt = S_ACTIVE;
                        w_pix_nxt   = '0;
                    end else begin
                        w_hcnt_nxt  = r_hcnt + 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (w_hs_fall || w_vs_fall) begin
                    w_err_nxt   = r_err | {w_vs_fall, w_hs_fall};
                    w_state_nxt = S_IDLE;
                end else if (i_pix_ce) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_addr;
                    w_wr_data_nxt = w_gray;
                    w_addr_nxt    = r_addr + 1'b1;
                    if (r_pix == H_LAST) begin
                        w_pix_nxt   = '0;
                        w_line_nxt  = r_line + 1'b1;
                        w_state_nxt = (r_line == V_LAST) ? S_DONE : S_WAIT_HS;
                    end else begin
                        w_pix_nxt   = r_pix + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_frame_done_nxt = 1'b1;
                w_state_nxt      = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // busy stays up through the frame_done cycle and drops the clk after.
    assign o_busy       = (r_state != S_IDLE) | r_frame_done;
    assign o_frame_done = r_frame_done;
    assign o_err        = r_err;

    assign o_fb.wr_en   = r_wr_en;
    assign o_fb.wr_addr = r_wr_addr;
    assign o_fb.wr_data = r_wr_data;

endmodule

// File: tb/tb_vga_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_capture
// Directed bench for vga_frame_capture on a tiny 8x4 frame (H_BP=2, V_BP=1)
// driven by a behavioural VGA source that holds each pixel slot for one
// pix_ce period.
// ---------------------------------------------------------------------------
module tb_vga_frame_capture;

    localparam int H_ACT  = 8;
    localparam int V_ACT  = 4;
    localparam int H_BP   = 2;
    localparam int V_BP   = 1;
    localparam int AW     = 5;
    localparam int HS_LEN = 2;
    localparam int FP_LEN = 2;

    logic       clk      = 1'b0;
    logic       rstN     = 1'b0;
    logic       pixCe    = 1'b0;
    logic       vgaHsync = 1'b1;
    logic       vgaVsync = 1'b1;
    logic [7:0] vgaR     = 8'd0;
    logic [7:0] vgaG     = 8'd0;
    logic [7:0] vgaB     = 8'd0;
    logic       arm      = 1'b0;
    logic       busy;
    logic       frameDone;
    logic [1:0] err;

    vga_frame_capture_if #(.AW(AW)) fbBus ();

    vga_frame_capture #(
        .H_ACTIVE (H_ACT),
        .V_ACTIVE (V_ACT),
        .H_BP     (H_BP),
        .V_BP     (V_BP),
        .AW       (AW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_pix_ce     (pixCe),
        .i_vga_hsync  (vgaHsync),
        .i_vga_vsync  (vgaVsync),
        .i_vga_r      (vgaR),
        .i_vga_g      (vgaG),
        .i_vga_b      (vgaB),
        .i_arm        (arm),
        .o_busy       (busy),
        .o_frame_done (frameDone),
        .o_err        (err),
        .o_fb         (fbBus)
    );

    // 100 MHz-style clock with a pixel strobe on every other cycle.
    initial forever #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        pixCe = ~pixCe;
    end

    int         compared   = 0;
    int         mismatched = 0;
    int         cycleNo    = 0;
    int         doneCount  = 0;
    int         wideCount  = 0;
    int         lastWrCycle   = -1;
    int         doneCycle     = -1;
    int         busyFallCycle = -1;
    logic       prevWrEn   = 1'b0;
    logic       prevBusy   = 1'b0;
    logic [AW-1:0] wrAddrQ[$];
    logic [7:0]    wrDataQ[$];
    logic [7:0]    expPat [4] = '{8'd63, 8'd255, 8'd1, 8'd127};

    // Logs every frame-buffer write plus frame_done/busy timing, sampled
    // on the falling edge away from the DUT's active edge.
    always @(negedge clk) begin
        cycleNo++;
        if (fbBus.wr_en) begin
            wrAddrQ.push_back(fbBus.wr_addr);
            wrDataQ.push_back(fbBus.wr_data);
            lastWrCycle = cycleNo;
            if (prevWrEn) wideCount++;
        end
        if (frameDone) begin
            doneCount++;
            doneCycle = cycleNo;
        end
        if (prevBusy && !busy) busyFallCycle = cycleNo;
        prevWrEn = fbBus.wr_en;
        prevBusy = busy;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        wrAddrQ.delete();
        wrDataQ.delete();
        doneCount     = 0;
        wideCount     = 0;
        lastWrCycle   = -1;
        doneCycle     = -1;
        busyFallCycle = -1;
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseArm();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Holds one pixel slot: pins change just after a strobe edge and stay
    // put until the next strobe edge.
    task automatic pixelSlot(input logic hs, input logic vs,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        vgaHsync = hs;
        vgaVsync = vs;
        vgaR     = r;
        vgaG     = g;
        vgaB     = b;
        @(posedge clk);
        while (pixCe !== 1'b1) @(posedge clk);
        #1;
    endtask

    // One line: hsync pulse, back porch, nPix pixels, front porch during
    // which vsync takes the value vsEnd. lineIdx < 0 sends a blank line.
    task automatic applyStimulus(input int lineIdx, input int nPix, input int fpLen,
                                 input logic vsEnd, input int mode);
        logic [7:0] v;
        for (int i = 0; i < HS_LEN; i++) pixelSlot(1'b0, vgaVsync, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < H_BP; i++)   pixelSlot(1'b1, vgaVsync, 8'd0, 8'd0, 8'd0);
        for (int p = 0; p < nPix; p++) begin
            if (lineIdx < 0) begin
                pixelSlot(1'b1, vgaVsync, 8'd0, 8'd0, 8'd0);
            end else if (mode == 0) begin
                v = 8'(lineIdx * H_ACT + p);
                pixelSlot(1'b1, vgaVsync, v, v, v);
            end else begin
                case (p % 4)
                    0:       pixelSlot(1'b1, vgaVsync, 8'd255, 8'd0,   8'd0);
                    1:       pixelSlot(1'b1, vgaVsync, 8'd255, 8'd255, 8'd255);
                    2:       pixelSlot(1'b1, vgaVsync, 8'd1,   8'd1,   8'd1);
                    default: pixelSlot(1'b1, vgaVsync, 8'd0,   8'd255, 8'd0);
                endcase
            end
        end
        for (int i = 0; i < fpLen; i++) pixelSlot(1'b1, vsEnd, 8'd0, 8'd0, 8'd0);
    endtask

    // A frame: vsync pulse spanning one line, V_BP-1 blank lines, then the
    // active lines. truncLine shortens one line; stopAfter drops vsync
    // after that many active lines.
    task automatic sendFrame(input int mode, input int truncLine, input int truncPix,
                             input int stopAfter);
        applyStimulus(-1, H_ACT, FP_LEN, 1'b0, mode);
        applyStimulus(-1, H_ACT, FP_LEN, 1'b1, mode);
        for (int b = 0; b < V_BP - 1; b++) applyStimulus(-1, H_ACT, FP_LEN, 1'b1, mode);
        for (int l = 0; l < V_ACT; l++) begin
            if (l == truncLine) begin
                applyStimulus(l, truncPix, 0, 1'b1, mode);
            end else if (l == stopAfter - 1) begin
                applyStimulus(l, H_ACT, FP_LEN, 1'b0, mode);
                break;
            end else begin
                applyStimulus(l, H_ACT, FP_LEN, 1'b1, mode);
            end
        end
    endtask

    initial begin
        int snap;

        // Reset state
        waitClocks(3);
        checkOutput("rst_busy",   busy,          0);
        checkOutput("rst_done",   frameDone,     0);
        checkOutput("rst_err",    err,           0);
        checkOutput("rst_wr_en",  fbBus.wr_en,   0);
        checkOutput("rst_addr",   fbBus.wr_addr, 0);
        checkOutput("rst_data",   fbBus.wr_data, 0);
        @(negedge clk);
        rstN = 1'b1;
        waitClocks(4);
        checkOutput("idle_busy", busy, 0);

        // Clean ramp frame
        $display("[TB] clean ramp frame");
        clearLog();
        pulseArm();
        checkOutput("arm_busy", busy, 1);
        sendFrame(0, -1, 0, -1);
        waitClocks(12);
        checkOutput("ramp_count", wrAddrQ.size(), 32);
        for (int i = 0; i < wrAddrQ.size(); i++) begin
            checkOutput($sformatf("ramp_addr%0d", i), wrAddrQ[i], i);
            checkOutput($sformatf("ramp_data%0d", i), wrDataQ[i], i);
        end
        checkOutput("ramp_done_cnt",  doneCount,     1);
        checkOutput("ramp_done_time", doneCycle,     lastWrCycle + 1);
        checkOutput("ramp_busy_fall", busyFallCycle, doneCycle + 1);
        checkOutput("ramp_wr_1clk",   wideCount,     0);
        checkOutput("ramp_err",       err,           0);
        checkOutput("ramp_busy_end",  busy,          0);

        // Colour-to-gray patterns
        $display("[TB] colour pattern frame");
        clearLog();
        pulseArm();
        sendFrame(1, -1, 0, -1);
        waitClocks(12);
        checkOutput("pat_count", wrAddrQ.size(), 32);
        for (int i = 0; i < wrAddrQ.size(); i++) begin
            checkOutput($sformatf("pat_addr%0d", i), wrAddrQ[i], i);
            checkOutput($sformatf("pat_data%0d", i), wrDataQ[i], expPat[i % 4]);
        end
        checkOutput("pat_done_cnt", doneCount, 1);

        // Short line on line 2
        $display("[TB] truncated line");
        clearLog();
        pulseArm();
        sendFrame(0, 2, 5, -1);
        waitClocks(12);
        checkOutput("trunc_count", wrAddrQ.size(), 21);
        if (wrAddrQ.size() > 0) checkOutput("trunc_last_addr", wrAddrQ[wrAddrQ.size()-1], 20);
        checkOutput("trunc_err",  err,       1);
        checkOutput("trunc_done", doneCount, 0);
        checkOutput("trunc_busy", busy,      0);

        // Short frame: vsync after two lines
        $display("[TB] short frame");
        clearLog();
        pulseArm();
        sendFrame(0, -1, 0, 2);
        waitClocks(12);
        checkOutput("short_count", wrAddrQ.size(), 16);
        checkOutput("short_err",   err,            2);
        checkOutput("short_done",  doneCount,      0);
        checkOutput("short_busy",  busy,           0);
        clearLog();
        pulseArm();
        checkOutput("rearm_err_clr", err,  0);
        checkOutput("rearm_busy",    busy, 1);
        sendFrame(0, -1, 0, -1);
        waitClocks(12);
        checkOutput("rearm_count", wrAddrQ.size(), 32);
        if (wrAddrQ.size() > 0) checkOutput("rearm_last_addr", wrAddrQ[wrAddrQ.size()-1], 31);
        checkOutput("rearm_done", doneCount, 1);
        checkOutput("rearm_err",  err,       0);

        // Arm mid-frame, then a second arm while busy
        $display("[TB] mid-frame arm");
        clearLog();
        fork
            sendFrame(0, -1, 0, -1);
            begin
                waitClocks(100);
                pulseArm();
            end
        join
        waitClocks(12);
        checkOutput("mid_no_writes", wrAddrQ.size(), 0);
        checkOutput("mid_busy",      busy,           1);
        clearLog();
        fork
            sendFrame(1, -1, 0, -1);
            begin
                waitClocks(100);
                pulseArm();
            end
        join
        waitClocks(12);
        checkOutput("mid_count", wrAddrQ.size(), 32);
        if (wrAddrQ.size() == 32) begin
            checkOutput("mid_addr31", wrAddrQ[31], 31);
            checkOutput("mid_data31", wrDataQ[31], 127);
        end
        checkOutput("mid_done", doneCount, 1);
        checkOutput("mid_busy_end", busy, 0);

        // Reset during the active region
        $display("[TB] reset mid-frame");
        clearLog();
        pulseArm();
        snap = 0;
        fork
            sendFrame(0, -1, 0, -1);
            begin
                waitClocks(100);
                @(posedge clk);
                #2;
                rstN = 1'b0;
                #1;
                checkOutput("mrst_busy",  busy,          0);
                checkOutput("mrst_done",  frameDone,     0);
                checkOutput("mrst_err",   err,           0);
                checkOutput("mrst_wr_en", fbBus.wr_en,   0);
                checkOutput("mrst_addr",  fbBus.wr_addr, 0);
                checkOutput("mrst_data",  fbBus.wr_data, 0);
                snap = wrAddrQ.size();
                waitClocks(3);
                rstN = 1'b1;
            end
        join
        waitClocks(12);
        checkOutput("mrst_no_writes", wrAddrQ.size(), snap);
        checkOutput("mrst_no_done",   doneCount,      0);
        checkOutput("mrst_idle",      busy,           0);
        clearLog();
        pulseArm();
        sendFrame(0, -1, 0, -1);
        waitClocks(12);
        checkOutput("post_rst_count", wrAddrQ.size(), 32);
        checkOutput("post_rst_done",  doneCount,      1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
